// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Walks a combinational gate under test through all 2**N_IN input vectors.
// Each vector is held for SETTLE cycles plus one sample cycle, then gate_out
// is captured into the truth table. After the last vector the table is compared
// with the expected pattern latched at start, and a one-cycle done pulse is issued.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start, gate_in parked at 0, results held
// S_SETTLE | gate_in = idx, counting down settle cycles in r_cnt
// S_SAMPLE | gate_out captured into table_q[idx] on the exit edge
// S_CHECK  | compare table_q with r_exp_q, pulse done, return to idle

module truth_table_sequencer #(
    parameter  int N_IN   = 2,
    parameter  int SETTLE = 1,
    localparam int V      = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [V-1:0]    i_expected,
    output logic [N_IN-1:0] o_gate_in,
    input  logic            i_gate_out,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [V-1:0]    o_table_q,
    output logic [N_IN:0]   o_mismatch_cnt
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(V - 1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_CHECK
    } state_t;

    state_t          r_state;
    logic [N_IN-1:0] r_idx;
    logic [CW-1:0]   r_cnt;
    logic [V-1:0]    r_exp_q;

    logic [V-1:0]    w_diff;
    logic [N_IN:0]   w_mismatch;

    assign w_diff = o_table_q ^ r_exp_q;

    // Population count of differing table bits, consumed only in S_CHECK.
    always_comb begin
        w_mismatch = '0;
        for (int i = 0; i < V; i++) begin
            w_mismatch = w_mismatch + {{N_IN{1'b0}}, w_diff[i]};
        end
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_exp_q        <= '0;
            o_gate_in      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_pass         <= 1'b0;
            o_table_q      <= '0;
            o_mismatch_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_gate_in <= '0;
                    if (i_start) begin
                        r_exp_q        <= i_expected;
                        r_idx          <= '0;
                        r_cnt          <= CNT_LOAD;
                        o_table_q      <= '0;
                        o_pass         <= 1'b0;
                        o_mismatch_cnt <= '0;
                        o_busy         <= 1'b1;
                        r_state        <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    o_table_q[r_idx] <= i_gate_out;
                    if (r_idx == IDX_LAST) begin
                        // Park the stimulus while the result is evaluated.
                        o_gate_in <= '0;
                        r_state   <= S_CHECK;
                    end else begin
                        r_idx     <= r_idx + IDX_ONE;
                        o_gate_in <= r_idx + IDX_ONE;
                        r_cnt     <= CNT_LOAD;
                        r_state   <= S_SETTLE;
                    end
                end
                S_CHECK: begin
                    o_pass         <= (o_table_q == r_exp_q);
                    o_mismatch_cnt <= w_mismatch;
                    o_done         <= 1'b1;
                    o_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: three instances (2-input S=1, 2-input S=3,
// 3-input S=1) share one clock and reset. Expected results are queued when a
// run is started and checked when the matching done pulse appears.

module tb_truth_table_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: N_IN=2, SETTLE=1, gate = AND or delayed AND
    logic       a_start, a_gout, a_busy, a_done, a_pass, a_dly;
    logic [3:0] a_exp, a_tab;
    logic [1:0] a_gin;
    logic [2:0] a_mcnt;
    // instance B: N_IN=2, SETTLE=3, gate = AND with 2-cycle registered delay
    logic       b_start, b_gout, b_busy, b_done, b_pass;
    logic [3:0] b_exp, b_tab;
    logic [1:0] b_gin;
    logic [2:0] b_mcnt;
    // instance C: N_IN=3, SETTLE=1, gate = 3-input XOR
    logic       c_start, c_gout, c_busy, c_done, c_pass;
    logic [7:0] c_exp, c_tab;
    logic [2:0] c_gin;
    logic [3:0] c_mcnt;

    logic a_d1, a_d2, b_d1, b_d2;
    always @(posedge clk) begin
        a_d1 <= &a_gin;
        a_d2 <= a_d1;
        b_d1 <= &b_gin;
        b_d2 <= b_d1;
    end
    assign a_gout = a_dly ? a_d2 : &a_gin;
    assign b_gout = b_d2;
    assign c_gout = ^c_gin;

    truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_expected(a_exp),
        .o_gate_in(a_gin), .i_gate_out(a_gout), .o_busy(a_busy), .o_done(a_done),
        .o_pass(a_pass), .o_table_q(a_tab), .o_mismatch_cnt(a_mcnt)
    );
    truth_table_sequencer #(.N_IN(2), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_expected(b_exp),
        .o_gate_in(b_gin), .i_gate_out(b_gout), .o_busy(b_busy), .o_done(b_done),
        .o_pass(b_pass), .o_table_q(b_tab), .o_mismatch_cnt(b_mcnt)
    );
    truth_table_sequencer #(.N_IN(3), .SETTLE(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .i_start(c_start), .i_expected(c_exp),
        .o_gate_in(c_gin), .i_gate_out(c_gout), .o_busy(c_busy), .o_done(c_done),
        .o_pass(c_pass), .o_table_q(c_tab), .o_mismatch_cnt(c_mcnt)
    );

    logic [2:0] w_done;
    assign w_done = {c_done, b_done, a_done};

    typedef struct {
        int         id;
        logic [7:0] tab;
        logic       pass;
        logic [3:0] mcnt;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   st_a = 0, st_b = 0, st_c = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int id, input logic [7:0] tab, input logic pass,
                           input logic [3:0] mcnt, input int lat);
        exp_t e;
        e.id   = id;
        e.tab  = tab;
        e.pass = pass;
        e.mcnt = mcnt;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int id, input logic [7:0] tab, input logic pass,
                          input logic [3:0] mcnt, input int lat);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(id), 32'hffff_ffff);
            return;
        end
        e = sb_q.pop_front();
        chk("run_id", 32'(id), 32'(e.id));
        chk("table_q", {24'h0, tab}, {24'h0, e.tab});
        chk("pass", {31'h0, pass}, {31'h0, e.pass});
        chk("mismatch_cnt", {28'h0, mcnt}, {28'h0, e.mcnt});
        chk("done_latency", 32'(lat), 32'(e.lat));
    endtask

    // Monitors: score each done pulse, then note the edge of any accepted start.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_done) sb_pop(0, {4'h0, a_tab}, a_pass, {1'b0, a_mcnt}, cyc - st_a);
            if (a_start && !a_busy) st_a = cyc + 1;
            if (b_done) sb_pop(1, {4'h0, b_tab}, b_pass, {1'b0, b_mcnt}, cyc - st_b);
            if (b_start && !b_busy) st_b = cyc + 1;
            if (c_done) sb_pop(2, c_tab, c_pass, c_mcnt, cyc - st_c);
            if (c_start && !c_busy) st_c = cyc + 1;
        end
    end

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       a_start = v;
            1:       b_start = v;
            default: c_start = v;
        endcase
    endtask

    task automatic pulse_start(input int id);
        @(posedge clk); #1;
        set_start(id, 1'b1);
        @(posedge clk); #1;
        set_start(id, 1'b0);
    endtask

    task automatic wait_done(input int id, input int max);
        int k = 0;
        while (!w_done[id] && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!w_done[id]) chk("done_timeout", 32'(id), 32'hffff_ffff);
    endtask

    initial begin
        int k;
        int ndone;
        a_start = 0; b_start = 0; c_start = 0;
        a_exp = '0;  b_exp = '0;  c_exp = '0;
        a_dly = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, a_busy}, 0);
        chk("rst_done", {31'h0, a_done}, 0);
        chk("rst_pass", {31'h0, a_pass}, 0);
        chk("rst_gate_in", {30'h0, a_gin}, 0);
        chk("rst_table", {28'h0, a_tab}, 0);
        chk("rst_mcnt", {29'h0, a_mcnt}, 0);
        chk("rst_c_table", {24'h0, c_tab}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // AND gate, expected AND; check the stimulus walk cycle by cycle
        a_exp = 4'b1000;
        sb_push(0, 8'h08, 1'b1, 4'd0, 9);
        pulse_start(0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("walk_gate_in", {30'h0, a_gin}, (i < 8) ? 32'(i / 2) : 0);
            chk("walk_busy", {31'h0, a_busy}, 1);
        end
        wait_done(0, 5);
        repeat (3) @(negedge clk);
        chk("hold_table", {28'h0, a_tab}, 32'h8);
        chk("hold_pass", {31'h0, a_pass}, 1);
        chk("idle_gate_in", {30'h0, a_gin}, 0);

        // AND gate against OR pattern; expected input changes mid-run
        a_exp = 4'b1110;
        sb_push(0, 8'h08, 1'b0, 4'd2, 9);
        pulse_start(0);
        repeat (2) @(posedge clk);
        #1 a_exp = 4'b0000;
        wait_done(0, 20);

        // start held high: back-to-back runs, busy low only in done cycles
        a_exp = 4'b1000;
        repeat (4) sb_push(0, 8'h08, 1'b1, 4'd0, 9);
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk);
        ndone = 0;
        k = 0;
        while (ndone < 3 && k < 60) begin
            @(negedge clk);
            chk("b2b_busy", {31'h0, a_busy}, {31'h0, !a_done});
            if (a_done) ndone++;
            k++;
        end
        if (ndone < 3) chk("b2b_timeout", 32'(ndone), 3);
        @(posedge clk); #1;
        a_start = 1'b0;
        wait_done(0, 20);

        // reset mid-run at idx 2
        sb_push(0, 8'h08, 1'b1, 4'd0, 9);
        pulse_start(0);
        k = 0;
        while (a_gin != 2'd2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reach_idx2", {30'h0, a_gin}, 2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, a_busy}, 0);
        chk("abort_done", {31'h0, a_done}, 0);
        chk("abort_pass", {31'h0, a_pass}, 0);
        chk("abort_gate_in", {30'h0, a_gin}, 0);
        chk("abort_table", {28'h0, a_tab}, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, a_done}, 0);
        end
        sb_push(0, 8'h08, 1'b1, 4'd0, 9);
        pulse_start(0);
        wait_done(0, 20);

        // delayed gate, SETTLE=1: every sample sees the previous vector
        a_dly = 1'b1;
        repeat (3) @(posedge clk);
        sb_push(0, 8'h00, 1'b0, 4'd1, 9);
        pulse_start(0);
        wait_done(0, 20);

        // delayed gate, SETTLE=3: enough settle time
        b_exp = 4'b1000;
        sb_push(1, 8'h08, 1'b1, 4'd0, 17);
        pulse_start(1);
        wait_done(1, 30);

        // 3-input XOR
        c_exp = 8'b1001_0110;
        sb_push(2, 8'h96, 1'b1, 4'd0, 17);
        pulse_start(2);
        wait_done(2, 30);

        repeat (3) @(negedge clk);
        chk("sb_leftover", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
